// File: rtl/toaplan2_prog_packer.sv
// Packs single-byte ROM download writes into 16-bit SDRAM programming writes,
// queued in a small FIFO with PROG_WE/PROG_RDY handshake and end-of-download flush.
module toaplan2_prog_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 23
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          DOWNLOADING,
  input  logic          IN_WR,
  input  logic [AW-1:0] IN_ADDR,
  input  logic [1:0]    IN_BA,
  input  logic [7:0]    IN_DATA,
  output logic          IN_WAIT,
  output logic [AW-2:0] PROG_ADDR,
  output logic [15:0]   PROG_DATA,
  output logic [1:0]    PROG_MASK,
  output logic [1:0]    PROG_BA,
  output logic          PROG_WE,
  input  logic          PROG_RDY,
  output logic          DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
    logic [1:0]    ba;
  } entry_t;

  entry_t fifo_q [FIFO_DEPTH];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic          in_wait_q, in_wait_d;
  logic          p_valid_q, p_valid_d;
  logic [AW-2:0] p_addr_q, p_addr_d;
  logic [1:0]    p_ba_q, p_ba_d;
  logic [7:0]    p_data_q, p_data_d;

  entry_t     push0, push1, pend_single, hi_single, head;
  logic [1:0] n_push;
  logic       accept, match, pop, empty;

  assign empty       = (count_q == '0);
  assign pop         = !empty && PROG_RDY;
  assign wr_ptr_p1   = wr_ptr_q + PW'(1);
  assign head        = fifo_q[rd_ptr_q];
  assign match       = p_valid_q && (p_addr_q == IN_ADDR[AW-1:1]) && (p_ba_q == IN_BA);
  assign pend_single = '{addr: p_addr_q, data: {p_data_q, p_data_q}, mask: 2'b10, ba: p_ba_q};
  assign hi_single   = '{addr: IN_ADDR[AW-1:1], data: {IN_DATA, IN_DATA}, mask: 2'b01, ba: IN_BA};
  // Writes are only taken while the download window is open and not draining.
  assign accept      = IN_WR && !in_wait_q && DOWNLOADING &&
                       (state_q == S_LOAD || state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    p_valid_d = p_valid_q;
    p_addr_d = p_addr_q;
    p_ba_d   = p_ba_q;
    p_data_d = p_data_q;
    push0    = '0;
    push1    = '0;
    n_push   = 2'd0;

    if (accept) begin
      if (!IN_ADDR[0]) begin
        if (p_valid_q) begin
          push0  = pend_single;
          n_push = 2'd1;
        end
        p_valid_d = 1'b1;
        p_addr_d  = IN_ADDR[AW-1:1];
        p_ba_d    = IN_BA;
        p_data_d  = IN_DATA;
      end else if (match) begin
        push0     = '{addr: p_addr_q, data: {IN_DATA, p_data_q}, mask: 2'b00, ba: p_ba_q};
        n_push    = 2'd1;
        p_valid_d = 1'b0;
      end else begin
        // Orphan low byte goes out ahead of the unmatched high byte.
        if (p_valid_q) begin
          push0  = pend_single;
          push1  = hi_single;
          n_push = 2'd2;
        end else begin
          push0  = hi_single;
          n_push = 2'd1;
        end
        p_valid_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE:  if (DOWNLOADING) state_d = S_LOAD;
      S_LOAD:  if (!DOWNLOADING) state_d = S_FLUSH;
      S_FLUSH: begin
        if (p_valid_q) begin
          if (count_q != CW'(FIFO_DEPTH)) begin
            push0     = pend_single;
            n_push    = 2'd1;
            p_valid_d = 1'b0;
          end
        end else if (empty) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    count_d  = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // Registered from next occupancy so a low IN_WAIT always leaves room for two pushes.
    in_wait_d = (count_d > CW'(FIFO_DEPTH - 2)) || (state_d == S_FLUSH) || (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_wait_q <= 1'b0;
      p_valid_q <= 1'b0;
      p_addr_q  <= '0;
      p_ba_q    <= '0;
      p_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      in_wait_q <= in_wait_d;
      p_valid_q <= p_valid_d;
      p_addr_q  <= p_addr_d;
      p_ba_q    <= p_ba_d;
      p_data_q  <= p_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (n_push != 2'd0 && wr_ptr_q == PW'(i)) begin
        fifo_q[i] <= push0;
      end else if (n_push == 2'd2 && wr_ptr_p1 == PW'(i)) begin
        fifo_q[i] <= push1;
      end
    end
  end

  assign IN_WAIT   = in_wait_q;
  assign PROG_WE   = !empty;
  assign PROG_ADDR = empty ? '0 : head.addr;
  assign PROG_DATA = empty ? '0 : head.data;
  assign PROG_MASK = empty ? 2'b11 : head.mask;
  assign PROG_BA   = empty ? 2'b00 : head.ba;
  assign DONE      = (state_q == S_DONE);

endmodule

// File: doc/toaplan2_prog_packer.md
# toaplan2_prog_packer

Byte-to-word write packer between the ROM download address decoder and the SDRAM controller programming port. It takes translated single-byte download writes and merges adjacent even/odd bytes into full 16-bit word writes. It queues the words in a 4-entry FIFO and drives the PROG_WE/PROG_RDY handshake. It also back-pressures the download stream and flushes any orphan byte at end of download.

## Interface
Parameters:
- FIFO_DEPTH, 4, output queue entries; power of two, ≥ 2.
- AW, 23, byte address width within a bank; PROG_ADDR is AW-1 bits.

Ports:
- CLK  in  1  system clock; every register is clocked on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DOWNLOADING  in  1  download window active.
- IN_WR  in  1  byte write strobe, one cycle per byte.
- IN_ADDR  in  AW  byte address within bank.
- IN_BA  in  2  target SDRAM bank.
- IN_DATA  in  8  byte value.
- IN_WAIT  out  1  upstream must not assert IN_WR while high.
- PROG_ADDR  out  AW-1  word address.
- PROG_DATA  out  16  word data.
- PROG_MASK  out  2  per-byte mask, 1 = byte not written; bit0 = low byte [7:0] = even address.
- PROG_BA  out  2  bank.
- PROG_WE  out  1  write request.
- PROG_RDY  in  1  controller accepted current write.
- DONE  out  1  one-cycle pulse: download finished and all writes retired.

## Operation
- Pending register holds one even byte: p_valid, p_addr (word), p_ba, p_data.
- Accepted write is IN_WR && !IN_WAIT. An IN_WR while IN_WAIT is high is a protocol error and is ignored.
- Accepted even byte with p_valid=0:
  - Store it in the pending register.
  - Nothing is pushed.
- Accepted even byte with p_valid=1:
  - Push the old pending entry as a single low byte: mask 2'b10, data {p_data,p_data}.
  - Store the new byte as pending.
- Accepted odd byte whose word address and BA match a valid pending entry:
  - Push {IN_DATA,p_data} with mask 2'b00.
  - Clear p_valid.
- Accepted odd byte with no match:
  - If p_valid=1, push the pending entry as a single low byte first.
  - Then push the odd byte as a single high byte: mask 2'b01, data {IN_DATA,IN_DATA}.
  - Clear p_valid.
- A single accepted write never pushes more than 2 entries. Pushes in the same cycle go in address-arrival order: pending entry first.
- IN_WAIT = (free entries < 2) || state==FLUSH.
- FIFO:
  - PROG_* are driven from the head entry; PROG_WE = !empty.
  - Head pops when PROG_WE && PROG_RDY.
  - Push and pop in the same cycle are both honoured; occupancy change is pushes − pops.
- FSM states and transitions:
  - IDLE → LOAD on DOWNLOADING=1.
  - LOAD → FLUSH on DOWNLOADING falling.
  - FLUSH: if p_valid, push the pending entry as a single byte and clear p_valid. Once p_valid=0 and the FIFO is empty, go to DONE.
  - DONE: assert DONE for one cycle → IDLE.
  - DOWNLOADING rising while in FLUSH or DONE: the flush completes first, then the FSM re-enters LOAD from IDLE. Bytes offered meanwhile are held off by IN_WAIT.
- IN_WR in IDLE (DOWNLOADING=0) is ignored.

## Timing
- Reset values: IN_WAIT=0, PROG_WE=0, PROG_ADDR=0, PROG_DATA=0, PROG_MASK=2'b11, PROG_BA=0, DONE=0. FIFO is empty, p_valid=0, FSM is IDLE.
- Reset mid-operation discards the pending byte and all queued writes. PROG_WE is low the cycle after RESET is sampled.
- Latency from an accepted odd byte completing a word to PROG_WE=1 with that word at an empty head: 1 cycle.
- PROG_* values are stable while PROG_WE=1 and PROG_RDY=0. After a pop, the next entry is presented the following cycle, so there is no bubble.
- IN_WAIT is registered from the next-cycle occupancy, so IN_WAIT=0 always guarantees room for 2 pushes.
- Full-rate streaming with PROG_RDY held at 1: one word retired per 2 bytes, and IN_WAIT never asserts.
- DONE is high exactly one cycle, at least 1 cycle after the last PROG_RDY pop.

## Test plan
- Bytes 0x11@0, 0x22@1, BA=1, PROG_RDY=1 → one write: ADDR 0, DATA 0x2211, MASK 2'b00, BA 1. Then DOWNLOADING falls → DONE pulse.
- Lone even byte 0xAA@4, then DOWNLOADING falls → flush write: ADDR 2, DATA 0xAAAA, MASK 2'b10, then DONE.
- Bytes 0x33@6, then 0x44@9 → two writes in order: (ADDR 3, MASK 2'b10, 0x3333), then (ADDR 4, MASK 2'b01, 0x4444).
- Same address pair but BA differs (byte@0 BA0, byte@1 BA1) → two single-byte writes, no merge.
- PROG_RDY held 0, streaming 8 bytes → FIFO reaches 3, IN_WAIT=1 and the stream stalls. PROG_RDY released → the 4 words retire in order with no data loss.
- RESET asserted while FIFO holds 3 entries and p_valid=1 → next cycle PROG_WE=0, IN_WAIT=0, and no DONE pulse.
